// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle for logic_unit_pipe.
// The master side is the operand producer and result consumer; the slave side is the pipe.
interface logic_unit_pipe_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
);
    localparam int unsigned ONES_W = $clog2(WIDTH + 1);

    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [2:0]        op;
    logic              acc_en;
    logic              acc_clr;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  y;
    logic [ONES_W-1:0] ones;
    logic              all_zero;
    logic              all_one;
    logic [CNT_W-1:0]  txn_count;

    modport master (
        output in_valid, a, b, op, acc_en, acc_clr, out_ready,
        input  in_ready, out_valid, y, ones, all_zero, all_one, txn_count
    );

    modport slave (
        input  in_valid, a, b, op, acc_en, acc_clr, out_ready,
        output in_ready, out_valid, y, ones, all_zero, all_one, txn_count
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// Two-stage bitwise gate pipe with valid/ready handshake, accumulate mode,
// popcount/flag annotation of each result and a delivered-result counter.
module logic_unit_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    logic_unit_pipe_if.slave bus
);
    localparam int unsigned ONES_W = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOR  = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_NAND = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    logic              s1_valid;
    logic [WIDTH-1:0]  s1_res;
    logic              s2_valid;
    logic [WIDTH-1:0]  y_q;
    logic [ONES_W-1:0] ones_q;
    logic              all_zero_q;
    logic              all_one_q;
    logic [CNT_W-1:0]  txn_q;
    logic [WIDTH-1:0]  acc;

    logic              s2_adv_c;
    logic              s1_adv_c;
    logic              accept_c;
    logic [WIDTH-1:0]  z_c;
    logic [WIDTH-1:0]  gate_c;

    function automatic logic [ONES_W-1:0] popcnt(input logic [WIDTH-1:0] v);
        logic [ONES_W-1:0] c;
        c = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            c = c + ONES_W'(v[i]);
        end
        return c;
    endfunction

    // Handshake advance and gate evaluation; a clear in the same cycle zeroes the acc operand.
    always_comb begin
        s2_adv_c = !s2_valid || bus.out_ready;
        s1_adv_c = !s1_valid || s2_adv_c;
        accept_c = bus.in_valid && s1_adv_c;
        z_c      = bus.b;
        if (bus.acc_en) begin
            z_c = bus.acc_clr ? '0 : acc;
        end
        gate_c = '0;
        case (bus.op)
            OP_AND:  gate_c = bus.a & z_c;
            OP_OR:   gate_c = bus.a | z_c;
            OP_NOR:  gate_c = ~(bus.a | z_c);
            OP_XOR:  gate_c = bus.a ^ z_c;
            OP_NAND: gate_c = ~(bus.a & z_c);
            OP_XNOR: gate_c = ~(bus.a ^ z_c);
            OP_NOT:  gate_c = ~bus.a;
            OP_PASS: gate_c = bus.a;
        endcase
    end

    // Accumulator: an accepted acc_en beat wins over a bare clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (accept_c && bus.acc_en) begin
            acc <= gate_c;
        end else if (bus.acc_clr) begin
            acc <= '0;
        end
    end

    // Stage 1: raw gate result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_res   <= '0;
        end else if (s1_adv_c) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_res <= gate_c;
            end
        end
    end

    // Stage 2: result plus annotations, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            y_q        <= '0;
            ones_q     <= '0;
            all_zero_q <= 1'b0;
            all_one_q  <= 1'b0;
        end else if (s2_adv_c) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                y_q        <= s1_res;
                ones_q     <= popcnt(s1_res);
                all_zero_q <= (s1_res == '0);
                all_one_q  <= (s1_res == '1);
            end
        end
    end

    // Delivered-result counter, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_q <= '0;
        end else if (s2_valid && bus.out_ready) begin
            txn_q <= txn_q + CNT_W'(1);
        end
    end

    assign bus.in_ready  = s1_adv_c;
    assign bus.out_valid = s2_valid;
    assign bus.y         = y_q;
    assign bus.ones      = ones_q;
    assign bus.all_zero  = all_zero_q;
    assign bus.all_one   = all_one_q;
    assign bus.txn_count = txn_q;
endmodule
